// File: rtl/ctrl_pkg.sv
// Shared opcode/FIFO constants, FSM state enum and strobe bundle for the
// crypto-datapath control sequencer.
package ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_LDB   = 5'd1;
  localparam logic [4:0] OP_STB   = 5'd2;
  localparam logic [4:0] OP_BR    = 5'd3;
  localparam logic [4:0] OP_BRZ   = 5'd4;
  localparam logic [4:0] OP_CRYPT = 5'd5;
  localparam logic [4:0] OP_HALT  = 5'd31;

  localparam logic [1:0] FIFO_EMPTY = 2'd0;
  localparam logic [1:0] FIFO_FULL  = 2'd3;
  localparam logic [1:0] AM_ILLEGAL = 2'd3;

  typedef enum logic [3:0] {
    IDLE, LOAD, FETCH, FETCH_W, DECODE, DEC_W, EXEC, WAIT_ENG, HALT
  } state_e;

  typedef struct packed {
    logic incr_pc;
    logic reset_pc;
    logic branch_offset_en;
    logic incr_pc_write;
    logic read_data;
    logic write_data;
    logic instrn_decode;
    logic read_flag;
    logic incr_data_read;
    logic write_flag;
    logic incr_data_write;
    logic engine_start;
  } strobe_t;

  function automatic logic op_legal(input logic [4:0] op);
    return op inside {OP_NOP, OP_LDB, OP_STB, OP_BR, OP_BRZ, OP_CRYPT, OP_HALT};
  endfunction

endpackage

// File: rtl/ctrl_sequencer_unit_if.sv
// Sequencer <-> datapath bundle: host load handshake, decoder/FIFO/engine
// status in, every datapath control strobe and status flag out.
interface ctrl_sequencer_unit_if;
  logic       prog_load, host_wr_valid, host_wr_ready, prog_done, run;
  logic [4:0] opcode;
  logic [1:0] operand_addr_mode;
  logic       start;
  logic [1:0] ptr_diff;
  logic       engine_done;
  logic       incr_pc, reset_pc, branch_offset_en, incr_pc_write;
  logic       read_data, write_data, instrn_decode;
  logic       read_flag, incr_data_read, write_flag, incr_data_write;
  logic       engine_start, busy, halted, error;

  modport master (
    input  prog_load, host_wr_valid, prog_done, run, opcode, operand_addr_mode,
           start, ptr_diff, engine_done,
    output host_wr_ready, incr_pc, reset_pc, branch_offset_en, incr_pc_write,
           read_data, write_data, instrn_decode, read_flag, incr_data_read,
           write_flag, incr_data_write, engine_start, busy, halted, error
  );

  modport slave (
    output prog_load, host_wr_valid, prog_done, run, opcode, operand_addr_mode,
           start, ptr_diff, engine_done,
    input  host_wr_ready, incr_pc, reset_pc, branch_offset_en, incr_pc_write,
           read_data, write_data, instrn_decode, read_flag, incr_data_read,
           write_flag, incr_data_write, engine_start, busy, halted, error
  );
endinterface

// File: rtl/seq_wait_counter.sv
// Loadable down-counter shared by the fetch, decode and engine waits;
// tc is high while the count sits at zero.
module seq_wait_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/ctrl_sequencer_unit.sv
// Fetch/decode/execute controller: sequences program load, instruction
// fetch/decode and opcode execution, driving registered one-cycle strobes.
module ctrl_sequencer_unit
  import ctrl_pkg::*;
#(
  parameter int FETCH_LAT   = 1,
  parameter int DEC_LAT     = 1,
  parameter int ENG_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  ctrl_sequencer_unit_if.master bus
);
  localparam int CW = $clog2(ENG_TIMEOUT + 4);

  localparam logic [3:0] S_IDLE     = 4'(IDLE);
  localparam logic [3:0] S_LOAD     = 4'(LOAD);
  localparam logic [3:0] S_FETCH    = 4'(FETCH);
  localparam logic [3:0] S_FETCH_W  = 4'(FETCH_W);
  localparam logic [3:0] S_DECODE   = 4'(DECODE);
  localparam logic [3:0] S_DEC_W    = 4'(DEC_W);
  localparam logic [3:0] S_EXEC     = 4'(EXEC);
  localparam logic [3:0] S_WAIT_ENG = 4'(WAIT_ENG);
  localparam logic [3:0] S_HALT     = 4'(HALT);

  logic [3:0]    state, state_nxt;
  strobe_t       strb_q, strb_nxt;
  logic          error_q, err_set, err_clr;
  logic          cnt_load, cnt_en, cnt_tc;
  logic [CW-1:0] cnt_val;
  logic          exec_illegal;

  assign exec_illegal = !op_legal(bus.opcode) || (bus.operand_addr_mode == AM_ILLEGAL);

  seq_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_nxt = state;
    strb_nxt  = '0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = '0;
    case (state)
      S_IDLE: begin
        if (bus.prog_load) begin
          err_clr   = 1'b1;
          state_nxt = S_LOAD;
        end else if (bus.run) begin
          strb_nxt.reset_pc = 1'b1;
          state_nxt         = S_FETCH;
        end
      end
      S_LOAD: begin
        // a write always completes before prog_done is honoured
        if (bus.host_wr_valid) begin
          strb_nxt.write_data    = 1'b1;
          strb_nxt.incr_pc_write = 1'b1;
        end else if (bus.prog_done) begin
          strb_nxt.reset_pc = 1'b1;
          state_nxt         = S_IDLE;
        end
      end
      S_FETCH: begin
        strb_nxt.read_data = 1'b1;
        cnt_load  = 1'b1;
        cnt_val   = CW'(FETCH_LAT - 1);
        state_nxt = S_FETCH_W;
      end
      S_FETCH_W: begin
        if (cnt_tc) state_nxt = S_DECODE;
        else        cnt_en    = 1'b1;
      end
      S_DECODE: begin
        strb_nxt.instrn_decode = 1'b1;
        cnt_load  = 1'b1;
        cnt_val   = CW'(DEC_LAT - 1);
        state_nxt = S_DEC_W;
      end
      S_DEC_W: begin
        if (cnt_tc) state_nxt = S_EXEC;
        else        cnt_en    = 1'b1;
      end
      S_EXEC: begin
        if (!bus.start) begin
          strb_nxt.incr_pc = 1'b1;
          state_nxt        = S_FETCH;
        end else if (exec_illegal) begin
          err_set   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          case (bus.opcode)
            OP_LDB: if (bus.ptr_diff != FIFO_EMPTY) begin
              strb_nxt.read_flag      = 1'b1;
              strb_nxt.incr_data_read = 1'b1;
              strb_nxt.incr_pc        = 1'b1;
              state_nxt               = S_FETCH;
            end
            OP_STB: if (bus.ptr_diff != FIFO_FULL) begin
              strb_nxt.write_flag      = 1'b1;
              strb_nxt.incr_data_write = 1'b1;
              strb_nxt.incr_pc         = 1'b1;
              state_nxt                = S_FETCH;
            end
            OP_BR: begin
              strb_nxt.branch_offset_en = 1'b1;
              state_nxt                 = S_FETCH;
            end
            OP_BRZ: begin
              if (bus.ptr_diff == FIFO_EMPTY) strb_nxt.branch_offset_en = 1'b1;
              else                            strb_nxt.incr_pc          = 1'b1;
              state_nxt = S_FETCH;
            end
            OP_CRYPT: begin
              strb_nxt.engine_start = 1'b1;
              cnt_load  = 1'b1;
              cnt_val   = CW'(ENG_TIMEOUT - 1);
              state_nxt = S_WAIT_ENG;
            end
            OP_HALT: state_nxt = S_HALT;
            default: begin
              strb_nxt.incr_pc = 1'b1;
              state_nxt        = S_FETCH;
            end
          endcase
        end
      end
      S_WAIT_ENG: begin
        // done in the timeout cycle still counts as success
        if (bus.engine_done) begin
          strb_nxt.incr_pc = 1'b1;
          state_nxt        = S_FETCH;
        end else if (ENG_TIMEOUT != 0 && cnt_tc) begin
          err_set   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_HALT:  if (!bus.run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      strb_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      strb_q <= strb_nxt;
      if (err_clr)      error_q <= 1'b0;
      else if (err_set) error_q <= 1'b1;
    end
  end

  assign bus.incr_pc          = strb_q.incr_pc;
  assign bus.reset_pc         = strb_q.reset_pc;
  assign bus.branch_offset_en = strb_q.branch_offset_en;
  assign bus.incr_pc_write    = strb_q.incr_pc_write;
  assign bus.read_data        = strb_q.read_data;
  assign bus.write_data       = strb_q.write_data;
  assign bus.instrn_decode    = strb_q.instrn_decode;
  assign bus.read_flag        = strb_q.read_flag;
  assign bus.incr_data_read   = strb_q.incr_data_read;
  assign bus.write_flag       = strb_q.write_flag;
  assign bus.incr_data_write  = strb_q.incr_data_write;
  assign bus.engine_start     = strb_q.engine_start;
  assign bus.host_wr_ready    = (state == S_LOAD);
  assign bus.busy             = (state != S_IDLE) && (state != S_HALT);
  assign bus.halted           = (state == S_HALT);
  assign bus.error            = error_q;
endmodule

// File: doc/ctrl_sequencer_unit.md
Name: ctrl_sequencer_unit

Overview:
Fetch/decode/execute controller for the crypto datapath. It drives every control strobe of the datapath: PC, instruction memory, decoder and data-memory FIFO. It consumes the decoder outputs and the data-memory status, sequences host program loading, and hands CRYPT operations to the crypto engine with a done handshake and a timeout.

Parameters:
FETCH_LAT, 1, cycles from read_data pulse to valid instruction at decoder input (1..3)
DEC_LAT, 1, cycles from instrn_decode pulse to valid opcode/start (1..3)
ENG_TIMEOUT, 64, max cycles waiting for engine_done; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
prog_load  in  1  host requests program-load mode (level)
host_wr_valid  in  1  host presents one 15-bit instruction on the memory data bus
host_wr_ready  out  1  high in LOAD; host write accepted when valid&ready
prog_done  in  1  host ends load (level, sampled in LOAD)
run  in  1  start execution from PC 0 (level)
opcode  in  5  from decoder
operand_addr_mode  in  2  from decoder; 2'b11 is illegal
start  in  1  decoder valid-instruction flag
ptr_diff  in  2  data FIFO occupancy: 0 = empty, 3 = full
engine_done  in  1  crypto engine completion pulse
incr_pc, reset_pc, branch_offset_en, incr_pc_write  out  1 each  PC control strobes
read_data, write_data  out  1 each  instruction memory strobes
instrn_decode  out  1  decoder enable
read_flag, incr_data_read, write_flag, incr_data_write  out  1 each  data FIFO strobes
engine_start  out  1  one-cycle engine launch
busy  out  1  high in any state except IDLE and HALT
halted  out  1  high in HALT
error  out  1  sticky; set on illegal opcode, illegal addr mode or engine timeout; cleared by reset or on entering LOAD

Behaviour:
- Reset: asynchronous. All outputs 0 and state IDLE immediately, including mid-operation. Timeout and latency counters are cleared.
- All strobes are registered single-cycle pulses unless stated otherwise.
- Opcodes (constants): NOP=0, LDB=1, STB=2, BR=3, BRZ=4, CRYPT=5, HALT=31. Any other opcode is illegal.
- IDLE:
  - If prog_load=1, go to LOAD. prog_load wins over run when both are high.
  - Else if run=1, pulse reset_pc, then go to FETCH.
- LOAD:
  - On each valid&ready cycle, pulse write_data and incr_pc_write together.
  - When prog_done=1 with no write in the same cycle, pulse reset_pc and go to IDLE. If a write and prog_done coincide, the write completes first and exit happens on the next cycle.
- FETCH: pulse read_data, then wait FETCH_LAT cycles.
- DECODE: pulse instrn_decode, then wait DEC_LAT cycles. Then sample start:
  - start=0: pulse incr_pc, go to FETCH.
  - start=1: go to EXEC.
- EXEC:
  - NOP: pulse incr_pc, go to FETCH.
  - LDB: stall while ptr_diff==0. Otherwise pulse read_flag and incr_data_read in the same cycle, plus incr_pc, then go to FETCH.
  - STB: stall while ptr_diff==3. Otherwise pulse write_flag and incr_data_write, plus incr_pc.
  - BR: pulse branch_offset_en only (no incr_pc).
  - BRZ: if ptr_diff==0, pulse branch_offset_en; else pulse incr_pc.
  - CRYPT: pulse engine_start, go to WAIT_ENG.
  - HALT: go to HALT; PC is not incremented.
  - Illegal opcode or operand_addr_mode==3: set error, go to HALT.
- WAIT_ENG:
  - Counter runs from 0. On engine_done, pulse incr_pc and go to FETCH.
  - If ENG_TIMEOUT!=0 and the count reaches ENG_TIMEOUT-1 without done: set error, go to HALT.
  - engine_done in the same cycle as the timeout: done wins.
- HALT: leave to IDLE when run==0. prog_load is ignored until then.
- Never assert incr_pc and branch_offset_en in the same cycle.
- Never assert read_data and write_data in the same cycle.
- Minimum instruction latency: 1 + FETCH_LAT + 1 + DEC_LAT + 1 cycles. This is 5 cycles at the defaults for NOP/LDB/STB/BR.

Decomposition:
- Shared package ctrl_pkg holds:
  - the opcode constants;
  - a state enum (IDLE, LOAD, FETCH, FETCH_W, DECODE, DEC_W, EXEC, WAIT_ENG, HALT);
  - the FIFO_EMPTY=0 and FIFO_FULL=3 constants.
- Natural sub-module: seq_wait_counter, a loadable down-counter with a terminal flag. It is reused for the FETCH_LAT, DEC_LAT and ENG_TIMEOUT waits.

Test Plan:
- Load 3 words: prog_load=1, three valid cycles, then prog_done -> exactly 3 write_data/incr_pc_write pulses; one reset_pc; error=0.
- NOP sequence: run=1, opcode=0, start=1, defaults -> read_data at cycle 1, instrn_decode at cycle 3, incr_pc at cycle 5, repeating every 5 cycles.
- LDB with ptr_diff=0 for 4 cycles, then 2 -> no read_flag while empty; read_flag, incr_data_read and incr_pc pulse together on the first cycle ptr_diff=2.
- BRZ: ptr_diff=0 -> branch_offset_en=1, incr_pc=0. Same instruction with ptr_diff=1 -> incr_pc=1, branch_offset_en=0.
- CRYPT with ENG_TIMEOUT=8, no engine_done -> engine_start once; error=1 and halted=1 eight cycles later. Repeat with engine_done on cycle 8 (the timeout cycle) -> done wins, incr_pc=1, error=0.
- Opcode 7 -> error=1, halted=1. Assert reset during WAIT_ENG -> all outputs 0 in the same cycle; after release, state is IDLE and error=0.
